// File: rtl/lsio_led_drv.sv
// LSIO LED driver: steady, blink and counted-burst patterns timed by the shared 1 ms tick.
// Burst completion is reported with a single-cycle done pulse.
module lsio_led_drv #(
    parameter int PERIOD_W   = 8,
    parameter int COUNT_W    = 5,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                one_ms_event_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [1:0]          cmd_mode_i,
    input  logic [PERIOD_W-1:0] cmd_half_period_i,
    input  logic [COUNT_W-1:0]  cmd_count_i,
    input  logic                abort_i,
    output logic                led_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [COUNT_W-1:0]  pulses_left_o
);

    typedef enum logic [1:0] {S_OFF, S_ON, S_BL_ON, S_BL_OFF} state_t;

    localparam logic [1:0] M_OFF   = 2'd0;
    localparam logic [1:0] M_ON    = 2'd1;
    localparam logic [1:0] M_BLINK = 2'd2;
    localparam logic [1:0] M_BURST = 2'd3;

    localparam logic UNLIT = (ACTIVE_LOW != 0);
    localparam logic LIT   = (ACTIVE_LOW == 0);

    localparam logic [PERIOD_W-1:0] P_ONE = 1;
    localparam logic [COUNT_W-1:0]  C_ONE = 1;

    state_t              state;
    logic                burst;
    logic [PERIOD_W-1:0] hp;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] hp_eff;
    logic                accept;
    logic                blinking;
    logic                phase_end;

    // A running burst locks out new commands until it finishes or is aborted.
    assign cmd_ready_o = ~abort_i & ~burst;
    assign accept      = cmd_valid_i & cmd_ready_o;
    assign hp_eff      = (cmd_half_period_i == '0) ? P_ONE : cmd_half_period_i;
    assign blinking    = (state == S_BL_ON) || (state == S_BL_OFF);
    assign phase_end   = (cnt + P_ONE) == hp;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= S_OFF;
            burst         <= 1'b0;
            hp            <= P_ONE;
            cnt           <= '0;
            pulses_left_o <= '0;
            led_o         <= UNLIT;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (abort_i) begin
                state         <= S_OFF;
                burst         <= 1'b0;
                cnt           <= '0;
                pulses_left_o <= '0;
                led_o         <= UNLIT;
                busy_o        <= 1'b0;
            end else if (accept) begin
                hp            <= hp_eff;
                cnt           <= '0;
                pulses_left_o <= '0;
                burst         <= 1'b0;
                unique case (cmd_mode_i)
                    M_OFF: begin
                        state  <= S_OFF;
                        led_o  <= UNLIT;
                        busy_o <= 1'b0;
                    end
                    M_ON: begin
                        state  <= S_ON;
                        led_o  <= LIT;
                        busy_o <= 1'b1;
                    end
                    M_BLINK: begin
                        state  <= S_BL_ON;
                        led_o  <= LIT;
                        busy_o <= 1'b1;
                    end
                    M_BURST: begin
                        if (cmd_count_i == '0) begin
                            state  <= S_OFF;
                            led_o  <= UNLIT;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end else begin
                            state         <= S_BL_ON;
                            led_o         <= LIT;
                            busy_o        <= 1'b1;
                            burst         <= 1'b1;
                            pulses_left_o <= cmd_count_i;
                        end
                    end
                endcase
            end else if (one_ms_event_i && blinking) begin
                if (phase_end) begin
                    cnt <= '0;
                    if (state == S_BL_ON) begin
                        state <= S_BL_OFF;
                        led_o <= UNLIT;
                    end else if (burst && pulses_left_o == C_ONE) begin
                        // last off-phase of the burst closes the pattern
                        state         <= S_OFF;
                        busy_o        <= 1'b0;
                        burst         <= 1'b0;
                        pulses_left_o <= '0;
                        done_o        <= 1'b1;
                    end else begin
                        state <= S_BL_ON;
                        led_o <= LIT;
                        if (burst) begin
                            pulses_left_o <= pulses_left_o - C_ONE;
                        end
                    end
                end else begin
                    cnt <= cnt + P_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsio_led_drv.sv
// Bench for lsio_led_drv: tick-count model of the lit/burst pattern feeding a scoreboard,
// checked against an active-high and an active-low build driven in lockstep.
module tb_lsio_led_drv;

    localparam int P_OFF   = 0;
    localparam int P_ON    = 1;
    localparam int P_BLINK = 2;
    localparam int P_BURST = 3;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       tick  = 1'b0;
    logic       valid = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] mode  = 2'd0;
    logic [7:0] hp    = 8'd0;
    logic [4:0] cnt   = 5'd0;

    logic       ready0, led0, busy0, done0;
    logic [4:0] pulses0;
    logic       ready1, led1, busy1, done1;
    logic [4:0] pulses1;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    int done_cnt = 0;

    int   m_pat  = P_OFF;
    int   m_k    = 0;
    int   m_hp   = 1;
    int   m_cnt  = 0;
    logic m_done = 1'b0;

    logic [7:0] sb_q[$];

    lsio_led_drv #(.PERIOD_W(8), .COUNT_W(5), .ACTIVE_LOW(0)) u_hi (
        .clk_i(clk), .rst_i(rst), .one_ms_event_i(tick),
        .cmd_valid_i(valid), .cmd_ready_o(ready0), .cmd_mode_i(mode),
        .cmd_half_period_i(hp), .cmd_count_i(cnt), .abort_i(abort),
        .led_o(led0), .busy_o(busy0), .done_o(done0), .pulses_left_o(pulses0)
    );

    lsio_led_drv #(.PERIOD_W(8), .COUNT_W(5), .ACTIVE_LOW(1)) u_lo (
        .clk_i(clk), .rst_i(rst), .one_ms_event_i(tick),
        .cmd_valid_i(valid), .cmd_ready_o(ready1), .cmd_mode_i(mode),
        .cmd_half_period_i(hp), .cmd_count_i(cnt), .abort_i(abort),
        .led_o(led1), .busy_o(busy1), .done_o(done1), .pulses_left_o(pulses1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    // {lit, busy, done, pulses_left}
    function automatic logic [7:0] m_exp();
        logic       lit;
        logic [4:0] pl;
        lit = 1'b0;
        pl  = 5'd0;
        if (m_pat == P_ON) lit = 1'b1;
        if (m_pat == P_BLINK || m_pat == P_BURST) lit = ((m_k / m_hp) % 2) == 0;
        if (m_pat == P_BURST) pl = 5'(m_cnt - m_k / (2 * m_hp));
        return {lit, m_pat != P_OFF, m_done, pl};
    endfunction

    task automatic model_reset();
        m_pat  = P_OFF;
        m_k    = 0;
        m_hp   = 1;
        m_cnt  = 0;
        m_done = 1'b0;
    endtask

    task automatic cyc(input logic v, input logic [1:0] m, input logic [7:0] h,
                       input logic [4:0] c, input logic a);
        logic       rdy_m;
        logic [7:0] e;
        valid = v;
        mode  = m;
        hp    = h;
        cnt   = c;
        abort = a;
        tick  = (cyc_n % 4 == 3);
        #1;
        rdy_m = !a && (m_pat != P_BURST);
        check("ready_hi", ready0, rdy_m);
        check("ready_lo", ready1, rdy_m);
        m_done = 1'b0;
        if (a) begin
            m_pat = P_OFF;
        end else if (v && rdy_m) begin
            m_k   = 0;
            m_hp  = (h == 0) ? 1 : int'(h);
            m_cnt = int'(c);
            case (m)
                2'd0: m_pat = P_OFF;
                2'd1: m_pat = P_ON;
                2'd2: m_pat = P_BLINK;
                default: begin
                    if (c == 0) begin
                        m_pat  = P_OFF;
                        m_done = 1'b1;
                    end else begin
                        m_pat = P_BURST;
                    end
                end
            endcase
        end else if (tick && (m_pat == P_BLINK || m_pat == P_BURST)) begin
            m_k++;
            if (m_pat == P_BURST && m_k == 2 * m_hp * m_cnt) begin
                m_pat  = P_OFF;
                m_done = 1'b1;
            end
        end
        sb_q.push_back(m_exp());
        @(posedge clk);
        #1;
        cyc_n++;
        if (done0) done_cnt++;
        e = sb_q.pop_front();
        check("out_hi", {led0, busy0, done0, pulses0}, e);
        check("out_lo", {~led1, busy1, done1, pulses1}, e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 8'd0, 5'd0, 1'b0);
    endtask

    task automatic run_burst(input int limit);
        int n;
        n = 0;
        while (m_pat == P_BURST && n < limit) begin
            cyc(1'b0, 2'd0, 8'd0, 5'd0, 1'b0);
            n++;
        end
        if (n >= limit) check("burst_timeout", 1, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", {led0, busy0, done0, pulses0}, 8'h00);
        check("rst_lo", {led1, busy1, done1, pulses1}, 8'h80);
        check("rst_ready", ready0, 1);
        rst = 1'b0;
        model_reset();

        while (cyc_n < 10) idle(1);
        cyc(1'b1, 2'd1, 8'd0, 5'd0, 1'b0);
        idle(20);
        cyc(1'b1, 2'd2, 8'd3, 5'd0, 1'b0);
        idle(60);

        done_cnt = 0;
        cyc(1'b1, 2'd3, 8'd2, 5'd3, 1'b0);
        cyc(1'b1, 2'd1, 8'd0, 5'd0, 1'b0);
        run_burst(400);
        check("burst3_done_cnt", done_cnt, 1);
        // command taken on the done cycle
        cyc(1'b1, 2'd2, 8'd1, 5'd0, 1'b0);
        idle(6);

        done_cnt = 0;
        cyc(1'b1, 2'd3, 8'd5, 5'd0, 1'b0);
        idle(8);
        check("burst0_done_cnt", done_cnt, 1);
        check("burst0_led", led0, 0);

        done_cnt = 0;
        cyc(1'b1, 2'd3, 8'd0, 5'd2, 1'b0);
        run_burst(400);
        check("hp0_done_cnt", done_cnt, 1);
        idle(3);

        done_cnt = 0;
        cyc(1'b1, 2'd3, 8'd2, 5'd5, 1'b0);
        begin
            int n;
            n = 0;
            while (!(m_pat == P_BURST && (m_k / (2 * m_hp)) == 1
                     && ((m_k / m_hp) % 2) == 0) && n < 200) begin
                idle(1);
                n++;
            end
            if (n >= 200) check("flash2_timeout", 1, 0);
        end
        cyc(1'b1, 2'd1, 8'd0, 5'd0, 1'b1);
        idle(12);
        check("abort_done_cnt", done_cnt, 0);

        cyc(1'b1, 2'd2, 8'd1, 5'd0, 1'b0);
        idle(9);
        #3;
        rst = 1'b1;
        #1;
        check("arst_led_hi", led0, 0);
        check("arst_led_lo", led1, 1);
        check("arst_busy", busy0, 0);
        check("arst_ready", ready0, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        done_cnt = 0;
        idle(10);
        check("arst_no_done", done_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
